prog_ram: RTL and testbench
===========================

Name: prog_ram

Overview:
- Parametrised single-clock synchronous RAM for the SAP-1.5 datapath.
- CPU port: write strobe (RI), output enable (RO), registered read data.
- Built-in sequencer:
  - zero-fills the array after reset (replaces hard-coded initial contents);
  - provides a streaming programming port that loads a program from address 0 upward with a valid/ready handshake while the CPU is held off.

Parameters:
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words
- CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset; 0 = skip straight to RUN

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- we  in  1  CPU write strobe (RI)
- oe  in  1  CPU output enable (RO)
- address  in  ADDR_WIDTH  CPU address
- data_in  in  DATA_WIDTH  CPU write data
- data_out  out  DATA_WIDTH  registered read data; zero when not enabled
- prog_mode  in  1  level request to enter programming mode
- prog_valid  in  1  prog_data valid
- prog_ready  out  1  block accepts a programming word this cycle
- prog_data  in  DATA_WIDTH  programming word
- prog_addr  out  ADDR_WIDTH  address the next programming word goes to
- prog_done  out  1  one-cycle pulse when the last word (DEPTH-1) is written
- busy  out  1  high whenever the CPU port is ignored

Behaviour:
- States: CLEAR, RUN, LOAD, HOLD. Held in the shared state enum.
- Reset (async, any state, including mid-load or mid-clear):
  - state = CLEAR if CLEAR_ON_RESET, else RUN
  - clear counter = 0, prog_addr = 0
  - data_out = 0, prog_ready = 0, prog_done = 0
  - busy = CLEAR_ON_RESET
  - Array contents are not reset asynchronously.
- CLEAR:
  - Writes 0 to word clr_cnt each cycle; clr_cnt increments.
  - After writing DEPTH-1: -> RUN, so clearing takes exactly DEPTH cycles.
  - CPU we ignored; data_out = 0; busy = 1.
  - prog_mode is ignored until the clear completes; if it is still high in RUN, LOAD is entered the next cycle.
- RUN:
  - busy = 0.
  - we=1: mem[address] <= data_in.
  - Read is registered, 1-cycle latency: data_out <= oe ? mem[address] : 0.
  - Same-address we and oe: data_out returns the OLD word (read-first).
  - prog_mode=1: -> LOAD, prog_addr <= 0; the CPU access in that cycle is still performed.
- LOAD:
  - busy = 1; prog_ready = 1 (registered, asserted from the first LOAD cycle); data_out = 0; CPU we ignored.
  - On prog_valid && prog_ready: mem[prog_addr] <= prog_data, prog_addr++.
  - Accepting the word at DEPTH-1:
    - prog_done pulses for 1 cycle; prog_addr wraps to 0; prog_ready drops next cycle; -> HOLD.
    - The state goes to HOLD even if prog_mode is already low.
  - prog_mode=0 before the last word: -> RUN next cycle.
    - Partial contents are kept; no prog_done.
    - A word handshaken in that same cycle is still written.
- HOLD:
  - busy = 1, prog_ready = 0; extra prog_valid is ignored (no write).
  - prog_mode=0: -> RUN.
- A new prog_mode assertion in RUN always restarts loading at address 0.
- Widths: all counters are ADDR_WIDTH bits with natural wrap; no arithmetic on data.

Decomposition:
- Shared package prog_ram_pkg:
  - state enum (CLEAR, RUN, LOAD, HOLD);
  - default width constants.
- One natural sub-module: ram_array.
  - Pure storage, single write port, registered read-first read port.
  - prog_ram muxes the write source (CPU / clear / load) into it.
- No other hierarchy.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=16 -> busy high for exactly 16 cycles; afterwards oe reads of all addresses return 8'h00 one cycle after each address is presented.
- RUN: we=1 address=4'h3 data_in=8'hA5, then oe=1 address=4'h3 -> data_out=8'hA5 next cycle; with oe=0 -> data_out=8'h00.
- Same-cycle we=1, oe=1 at address=4'h7 holding 8'h11, data_in=8'h22 -> data_out=8'h11; next read -> 8'h22.
- prog_mode=1, stream 16 words 8'h10..8'h1F with prog_valid toggling every other cycle:
  - prog_addr steps 0..15, then wraps to 0;
  - prog_done pulses once, on the cycle word 15 is accepted;
  - after prog_mode=0, busy=0 and mem[i]=8'h10+i.
- Drop prog_mode after 5 words (8'hC0..8'hC4) -> RUN next cycle, no prog_done; words 0-4 hold the new data, words 5-15 are unchanged.
- Assert reset while in LOAD at prog_addr=9 -> prog_ready=0, prog_addr=0 immediately; clear sequence reruns and every word reads 8'h00.

Source files
------------

// File: rtl/prog_ram_pkg.sv
// Shared types and default widths for the SAP-1.5 program RAM.
package prog_ram_pkg;

  // Sequencer states: zero-fill, normal CPU access, program streaming, wait-for-release.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

endpackage

// File: rtl/prog_ram_array.sv
// Pure storage: one write port and one registered, read-first read port.
module ram_array #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write and read share one edge, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rd_data_q <= mem[raddr];
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/prog_ram.sv
// SAP-1.5 program RAM: CPU port plus a sequencer that zero-fills after reset
// and streams a program in from address 0 while the CPU is held off.
module prog_ram
  import prog_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  oe,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  prog_mode,
  input  logic                  prog_valid,
  output logic                  prog_ready,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic                  prog_done,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_WIDTH-1:0]   prog_addr_q, prog_addr_d;
  logic                    prog_ready_q, prog_ready_d;
  logic                    prog_done_q, prog_done_d;
  logic                    busy_q, busy_d;
  logic                    out_en_q, out_en_d;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (address),
    .rdata (mem_rdata)
  );

  // Next-state logic and write-source mux (clear counter, CPU or programming stream).
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    prog_addr_d  = prog_addr_q;
    prog_ready_d = prog_ready_q;
    prog_done_d  = 1'b0;
    out_en_d     = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = address;
    mem_wdata    = data_in;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + ADDR_ONE;
        if (clr_cnt_q == ADDR_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_we   = we;
        out_en_d = oe;
        if (prog_mode) begin
          state_d      = ST_LOAD;
          prog_addr_d  = '0;
          prog_ready_d = 1'b1;
        end
      end
      ST_LOAD: begin
        mem_waddr = prog_addr_q;
        mem_wdata = prog_data;
        if (prog_valid && prog_ready_q) begin
          mem_we      = 1'b1;
          prog_addr_d = prog_addr_q + ADDR_ONE;
          if (prog_addr_q == ADDR_LAST) begin
            state_d      = ST_HOLD;
            prog_done_d  = 1'b1;
            prog_ready_d = 1'b0;
          end
        end
        if ((state_d == ST_LOAD) && !prog_mode) begin
          state_d      = ST_RUN;
          prog_ready_d = 1'b0;
        end
      end
      ST_HOLD: begin
        prog_ready_d = 1'b0;
        if (!prog_mode) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    busy_d = (state_d != ST_RUN);
  end

  // State and registered outputs; reset lands in CLEAR or RUN depending on CLEAR_ON_RESET.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q    <= '0;
      prog_addr_q  <= '0;
      prog_ready_q <= 1'b0;
      prog_done_q  <= 1'b0;
      busy_q       <= (CLEAR_ON_RESET != 0);
      out_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      prog_addr_q  <= prog_addr_d;
      prog_ready_q <= prog_ready_d;
      prog_done_q  <= prog_done_d;
      busy_q       <= busy_d;
      out_en_q     <= out_en_d;
    end
  end

  assign data_out   = out_en_q ? mem_rdata : '0;
  assign prog_ready = prog_ready_q;
  assign prog_addr  = prog_addr_q;
  assign prog_done  = prog_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_prog_ram.sv
// Directed bench for prog_ram: clear after reset, CPU read/write, full and
// partial program loads, and reset in the middle of a load.
module tb_prog_ram;

  logic       clk;
  logic       reset;
  logic       we;
  logic       oe;
  logic [3:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       prog_mode;
  logic       prog_valid;
  logic       prog_ready;
  logic [7:0] prog_data;
  logic [3:0] prog_addr;
  logic       prog_done;
  logic       busy;

  int checks;
  int failures;
  int busyCycles;

  prog_ram #(
    .DATA_WIDTH     (8),
    .ADDR_WIDTH     (4),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .oe         (oe),
    .address    (address),
    .data_in    (data_in),
    .data_out   (data_out),
    .prog_mode  (prog_mode),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_data  (prog_data),
    .prog_addr  (prog_addr),
    .prog_done  (prog_done),
    .busy       (busy)
  );

  // 10-time-unit system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the CPU port
  task automatic applyStimulus(input logic w, input logic o, input logic [3:0] a, input logic [7:0] d);
    we      = w;
    oe      = o;
    address = a;
    data_in = d;
  endtask

  // One comparison: count it, and report a failure with observed/expected
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Count cycles busy stays high after reset release, bounded at 40
  task automatic countBusy(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      n++;
      tick();
    end
  endtask

  // Present an address with oe=1 and compare the word returned one cycle later
  task automatic readCheck(input string tag, input logic [3:0] a, input logic [7:0] exp);
    applyStimulus(1'b0, 1'b1, a, 8'h00);
    tick();
    checkOutput(tag, 32'(data_out), 32'(exp));
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    prog_mode  = 1'b0;
    prog_valid = 1'b0;
    prog_data  = 8'h00;
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);

    // Reset state
    tick();
    tick();
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_ready", 32'(prog_ready), 32'd0);
    checkOutput("rst_addr", 32'(prog_addr), 32'd0);
    checkOutput("rst_done", 32'(prog_done), 32'd0);
    checkOutput("rst_dout", 32'(data_out), 32'd0);

    // Clear takes exactly 16 cycles, then everything reads zero
    reset = 1'b0;
    countBusy(busyCycles);
    checkOutput("clear_cycles", 32'(busyCycles), 32'd16);
    for (int i = 0; i < 16; i++) readCheck("clear_read", 4'(i), 8'h00);

    // Basic write then read; oe=0 gives zero
    applyStimulus(1'b1, 1'b0, 4'h3, 8'hA5);
    tick();
    readCheck("run_read", 4'h3, 8'hA5);
    applyStimulus(1'b0, 1'b0, 4'h3, 8'h00);
    tick();
    checkOutput("run_oe_low", 32'(data_out), 32'd0);

    // Read-first on same-address write
    applyStimulus(1'b1, 1'b0, 4'h7, 8'h11);
    tick();
    applyStimulus(1'b1, 1'b1, 4'h7, 8'h22);
    tick();
    checkOutput("rf_old", 32'(data_out), 32'h11);
    readCheck("rf_new", 4'h7, 8'h22);
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);

    // Full program load with prog_valid toggling
    prog_mode = 1'b1;
    tick();
    checkOutput("load_ready", 32'(prog_ready), 32'd1);
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkOutput("load_addr0", 32'(prog_addr), 32'd0);
    for (int i = 0; i < 16; i++) begin
      prog_valid = 1'b0;
      tick();
      checkOutput("load_idle_addr", 32'(prog_addr), 32'(i));
      checkOutput("load_idle_done", 32'(prog_done), 32'd0);
      prog_valid = 1'b1;
      prog_data  = 8'(8'h10 + i);
      tick();
      checkOutput("load_step_addr", 32'(prog_addr), 32'((i + 1) % 16));
      checkOutput("load_step_done", 32'(prog_done), (i == 15) ? 32'd1 : 32'd0);
    end
    checkOutput("load_end_ready", 32'(prog_ready), 32'd0);
    prog_valid = 1'b0;
    tick();
    checkOutput("hold_done", 32'(prog_done), 32'd0);
    checkOutput("hold_busy", 32'(busy), 32'd1);
    prog_valid = 1'b1;
    prog_data  = 8'hFF;
    tick();
    prog_valid = 1'b0;
    prog_mode  = 1'b0;
    tick();
    checkOutput("release_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 16; i++) readCheck("load_mem", 4'(i), 8'(8'h10 + i));

    // Partial load of five words; CPU write during load is ignored
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
    prog_mode = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b1, 4'hF, 8'hEE);
    for (int i = 0; i < 5; i++) begin
      prog_valid = 1'b1;
      prog_data  = 8'(8'hC0 + i);
      if (i == 4) prog_mode = 1'b0;
      tick();
      checkOutput("part_done", 32'(prog_done), 32'd0);
      if (i < 4) begin
        checkOutput("part_dout", 32'(data_out), 32'd0);
        checkOutput("part_busy", 32'(busy), 32'd1);
      end
    end
    prog_valid = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
    checkOutput("part_run_busy", 32'(busy), 32'd0);
    checkOutput("part_run_ready", 32'(prog_ready), 32'd0);
    for (int i = 0; i < 16; i++) begin
      readCheck("part_mem", 4'(i), (i < 5) ? 8'(8'hC0 + i) : 8'(8'h10 + i));
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);

    // Reset in the middle of a load at prog_addr=9
    prog_mode = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      prog_valid = 1'b1;
      prog_data  = 8'h55;
      tick();
    end
    checkOutput("mid_addr9", 32'(prog_addr), 32'd9);
    prog_valid = 1'b0;
    prog_mode  = 1'b0;
    reset      = 1'b1;
    #1;
    checkOutput("mid_rst_ready", 32'(prog_ready), 32'd0);
    checkOutput("mid_rst_addr", 32'(prog_addr), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd1);
    tick();
    reset = 1'b0;
    countBusy(busyCycles);
    checkOutput("mid_clear_cycles", 32'(busyCycles), 32'd16);
    for (int i = 0; i < 16; i++) readCheck("mid_clear_read", 4'(i), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
